// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and sizing for the iterative multiply/divide unit
package muldiv_pkg;
  localparam int MD_WIDTH = 32;
  localparam int MD_ITER = 32;
  typedef enum logic [1:0] {MUL, MULHU, DIVU, REMU} muldiv_op_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} muldiv_state_t;
endpackage

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: issue/result handshake between the execute stage and the multiply/divide unit
interface ex_muldiv_if;
  import muldiv_pkg::*;
  logic start;
  muldiv_op_t op;
  logic [MD_WIDTH-1:0] opA;
  logic [MD_WIDTH-1:0] opB;
  logic [3:0] DestR_in;
  logic flush;
  logic [MD_WIDTH-1:0] result;
  logic [3:0] DestR_out;
  logic done;
  logic busy;
  logic stall;
  logic dz;
  modport master(output start, op, opA, opB, DestR_in, flush,
                 input result, DestR_out, done, busy, stall, dz);
  modport slave(input start, op, opA, opB, DestR_in, flush,
                output result, DestR_out, done, busy, stall, dz);
endinterface

// File: rtl/muldiv_dp.sv
// muldiv_dp: radix-2 shift-add multiplier and restoring divider sharing one 64-bit register
// The divider half is present only when MULDIV_DIV_EN is defined.
module muldiv_dp
  import muldiv_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    step,
`ifdef MULDIV_DIV_EN
  input  logic                    div,
`endif
  input  logic [MD_WIDTH-1:0]     a,
  input  logic [MD_WIDTH-1:0]     b,
  output logic [2*MD_WIDTH-1:0]   nxt
);
  logic [2*MD_WIDTH-1:0] p;
  logic [MD_WIDTH-1:0] bq;
  logic [MD_WIDTH:0] add;
`ifdef MULDIV_DIV_EN
  logic [MD_WIDTH:0] sh;
  logic ge;
`endif
  always_comb begin
    add = {1'b0, p[2*MD_WIDTH-1:MD_WIDTH]} + (p[0] ? {1'b0, bq} : '0);
`ifdef MULDIV_DIV_EN
    sh = {p[2*MD_WIDTH-1:MD_WIDTH], p[MD_WIDTH-1]};
    ge = sh >= {1'b0, bq};
    nxt = !div ? {add, p[MD_WIDTH-1:1]} :
          ge   ? {MD_WIDTH'(sh - {1'b0, bq}), p[MD_WIDTH-2:0], 1'b1} :
                 {sh[MD_WIDTH-1:0], p[MD_WIDTH-2:0], 1'b0};
`else
    nxt = {add, p[MD_WIDTH-1:1]};
`endif
  end
  // High half is the partial product / partial remainder, low half the multiplier / quotient
  always_ff @(posedge clk) begin
    if (rst) begin
      p <= '0;
      bq <= '0;
    end else if (load) begin
      p <= {{MD_WIDTH{1'b0}}, a};
      bq <= b;
    end else if (step) begin
      p <= nxt;
    end
  end
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: 32-cycle unsigned MUL/MULHU/DIVU/REMU unit with IDLE/RUN/DONE control
// Define MULDIV_DIV_EN to build the divider; otherwise divide ops finish at once with dz set.
module ex_muldiv
  import muldiv_pkg::*;
(
  input logic clk,
  input logic rst,
  ex_muldiv_if.slave bus
);
  muldiv_state_t state, state_n;
  muldiv_op_t op_q;
  logic [3:0] tag_q;
  logic [4:0] cnt;
  logic accept, zdiv, last;
  logic [MD_WIDTH-1:0] zres;
  logic [2*MD_WIDTH-1:0] nxt;
  muldiv_dp u_dp (
    .clk(clk),
    .rst(rst),
    .load(accept),
    .step(state == RUN && !bus.flush),
`ifdef MULDIV_DIV_EN
    .div(op_q inside {DIVU, REMU}),
`endif
    .a(bus.opA),
    .b(bus.opB),
    .nxt(nxt)
  );
  always_comb begin
    accept = state == IDLE && bus.start && !bus.flush;
`ifdef MULDIV_DIV_EN
    zdiv = bus.op inside {DIVU, REMU} && bus.opB == '0;
    zres = bus.op == REMU ? bus.opA : {MD_WIDTH{1'b1}};
`else
    zdiv = bus.op inside {DIVU, REMU};
    zres = '0;
`endif
    last = state == RUN && !bus.flush && cnt == 5'(MD_ITER - 1);
    state_n = state == IDLE ? (accept ? (zdiv ? DONE : RUN) : IDLE) :
              state == RUN  ? (bus.flush ? IDLE : last ? DONE : RUN) : IDLE;
    bus.done = state == DONE && !bus.flush;
    bus.busy = state != IDLE;
    bus.stall = !rst && (accept || state == RUN);
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // Visible outputs only change on entry to DONE, so a flush keeps the last result
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= MUL;
      tag_q <= '0;
      cnt <= '0;
      bus.result <= '0;
      bus.DestR_out <= '0;
      bus.dz <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= bus.op;
        tag_q <= bus.DestR_in;
        cnt <= '0;
      end
      if (state == RUN) cnt <= cnt + 5'd1;
      if (accept && zdiv) begin
        bus.result <= zres;
        bus.DestR_out <= bus.DestR_in;
        bus.dz <= 1'b1;
      end
      if (last) begin
        bus.result <= op_q inside {MULHU, REMU} ? nxt[2*MD_WIDTH-1:MD_WIDTH] : nxt[MD_WIDTH-1:0];
        bus.DestR_out <= tag_q;
        bus.dz <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed self-checking bench for ex_muldiv (honours MULDIV_DIV_EN)
module tb_ex_muldiv;
  import muldiv_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vecs = 0;
  int errs = 0;
  ex_muldiv_if bus();
  ex_muldiv dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  // Issue one op at a negedge; returns the cycle done was seen (0 = never) and
  // whether stall misbehaved (must be 1 every cycle before done, 0 in the done cycle).
  task automatic issue(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] t, output int lat, output logic stall_bad);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.opA = a; bus.opB = b; bus.DestR_in = t;
    lat = 0; stall_bad = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      #1;
      if (bus.done) begin
        lat = c;
        if (bus.stall) stall_bad = 1'b1;
        break;
      end
      if (!bus.stall) stall_bad = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.start = 1'b1; bus.flush = 1'b0; bus.op = MUL;
    bus.opA = 32'd3; bus.opB = 32'd4; bus.DestR_in = 4'd1;
    repeat (2) @(negedge clk);
    #1;
    vecs++; if (bus.stall !== 1'b0) begin errs++; $display("FAIL rst_stall got %b want 0", bus.stall); end
    vecs++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errs++; $display("FAIL rst_busy_done got %b%b want 00", bus.busy, bus.done); end
    vecs++; if (bus.result !== 32'd0 || bus.DestR_out !== 4'd0 || bus.dz !== 1'b0) begin errs++; $display("FAIL rst_outputs got %h/%h/%b want 0/0/0", bus.result, bus.DestR_out, bus.dz); end
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    @(negedge clk); #1;
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL rst_start_ignored got busy %b want 0", bus.busy); end
  endtask

  task automatic test_mul;
    int lat; logic sb;
    issue(MUL, 32'd7, 32'd6, 4'd5, lat, sb);
    vecs++; if (lat !== 34) begin errs++; $display("FAIL mul_latency got %0d want 34", lat); end
    vecs++; if (sb !== 1'b0) begin errs++; $display("FAIL mul_stall got bad=%b want 0", sb); end
    vecs++; if (bus.result !== 32'd42) begin errs++; $display("FAIL mul_7x6 got %0d want 42", bus.result); end
    vecs++; if (bus.DestR_out !== 4'd5 || bus.dz !== 1'b0) begin errs++; $display("FAIL mul_tag_dz got %0d/%b want 5/0", bus.DestR_out, bus.dz); end
    issue(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd6, lat, sb);
    vecs++; if (lat !== 34 || bus.result !== 32'hFFFFFFFE) begin errs++; $display("FAIL mulhu_max got %h lat %0d want fffffffe lat 34", bus.result, lat); end
    issue(MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd7, lat, sb);
    vecs++; if (bus.result !== 32'h00000001) begin errs++; $display("FAIL mul_max got %h want 00000001", bus.result); end
    @(negedge clk); #1;
    vecs++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errs++; $display("FAIL done_one_cycle got done %b busy %b want 0 0", bus.done, bus.busy); end
    vecs++; if (bus.result !== 32'h00000001 || bus.DestR_out !== 4'd7) begin errs++; $display("FAIL result_hold got %h/%0d want 00000001/7", bus.result, bus.DestR_out); end
  endtask

  task automatic test_div;
    int lat; logic sb;
`ifdef MULDIV_DIV_EN
    issue(DIVU, 32'd100, 32'd7, 4'd2, lat, sb);
    vecs++; if (lat !== 34 || bus.result !== 32'd14 || bus.dz !== 1'b0) begin errs++; $display("FAIL divu_100_7 got %0d dz %b lat %0d want 14 dz 0 lat 34", bus.result, bus.dz, lat); end
    issue(REMU, 32'd100, 32'd7, 4'd3, lat, sb);
    vecs++; if (bus.result !== 32'd2) begin errs++; $display("FAIL remu_100_7 got %0d want 2", bus.result); end
    issue(DIVU, 32'hFFFFFFFF, 32'd1, 4'd3, lat, sb);
    vecs++; if (bus.result !== 32'hFFFFFFFF) begin errs++; $display("FAIL divu_max_1 got %h want ffffffff", bus.result); end
    issue(DIVU, 32'd9, 32'd0, 4'd4, lat, sb);
    vecs++; if (lat !== 2 || sb !== 1'b0) begin errs++; $display("FAIL divu_dz_latency got %0d stallbad %b want 2 0", lat, sb); end
    vecs++; if (bus.result !== 32'hFFFFFFFF || bus.dz !== 1'b1 || bus.DestR_out !== 4'd4) begin errs++; $display("FAIL divu_9_0 got %h dz %b tag %0d want ffffffff 1 4", bus.result, bus.dz, bus.DestR_out); end
    issue(REMU, 32'd9, 32'd0, 4'd4, lat, sb);
    vecs++; if (bus.result !== 32'd9 || bus.dz !== 1'b1) begin errs++; $display("FAIL remu_9_0 got %0d dz %b want 9 1", bus.result, bus.dz); end
`else
    issue(DIVU, 32'd9, 32'd0, 4'd4, lat, sb);
    vecs++; if (lat !== 2 || bus.result !== 32'd0 || bus.dz !== 1'b1) begin errs++; $display("FAIL nodiv_divu got %h dz %b lat %0d want 0 1 2", bus.result, bus.dz, lat); end
    issue(REMU, 32'd100, 32'd7, 4'd4, lat, sb);
    vecs++; if (lat !== 2 || bus.result !== 32'd0 || bus.dz !== 1'b1) begin errs++; $display("FAIL nodiv_remu got %h dz %b lat %0d want 0 1 2", bus.result, bus.dz, lat); end
`endif
    issue(MUL, 32'd3, 32'd5, 4'd8, lat, sb);
    vecs++; if (bus.result !== 32'd15 || bus.dz !== 1'b0) begin errs++; $display("FAIL dz_clear got %0d dz %b want 15 0", bus.result, bus.dz); end
  endtask

  task automatic test_flush;
    int lat; logic sb; logic seen;
    issue(MUL, 32'd2, 32'd2, 4'd9, lat, sb);
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = MUL; bus.opA = 32'd5; bus.opB = 32'd5; bus.DestR_in = 4'd3;
    #1;
    vecs++; if (bus.stall !== 1'b0) begin errs++; $display("FAIL flush_start_stall got %b want 0", bus.stall); end
    @(negedge clk);
    bus.flush = 1'b0; #1;
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL flush_wins_idle got busy %b want 0", bus.busy); end
    for (int c = 2; c <= 11; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0; #1;
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL flush_to_idle got busy %b want 0", bus.busy); end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk); #1;
      if (bus.done) seen = 1'b1;
    end
    vecs++; if (seen !== 1'b0) begin errs++; $display("FAIL flush_no_done got done seen %b want 0", seen); end
    vecs++; if (bus.DestR_out !== 4'd9 || bus.result !== 32'd4) begin errs++; $display("FAIL flush_hold got %0d/%0d want 9/4", bus.DestR_out, bus.result); end
    issue(MUL, 32'd3, 32'd3, 4'd1, lat, sb);
    vecs++; if (lat !== 34 || bus.result !== 32'd9 || bus.DestR_out !== 4'd1) begin errs++; $display("FAIL after_flush got %0d tag %0d lat %0d want 9 1 34", bus.result, bus.DestR_out, lat); end
  endtask

  task automatic test_start_ignored;
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.op = MUL; bus.opA = 32'd1000; bus.opB = 32'd1000; bus.DestR_in = 4'd7;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      #1;
      if (bus.done) begin lat = c; break; end
      @(negedge clk);
      bus.start = (c + 1 == 6);
      if (c + 1 == 6) begin bus.op = DIVU; bus.opA = 32'd1; bus.opB = 32'd1; bus.DestR_in = 4'd2; end
    end
    bus.start = 1'b0;
    vecs++; if (lat !== 34) begin errs++; $display("FAIL start_in_run_latency got %0d want 34", lat); end
    vecs++; if (bus.result !== 32'd1000000 || bus.DestR_out !== 4'd7) begin errs++; $display("FAIL start_in_run got %0d tag %0d want 1000000 7", bus.result, bus.DestR_out); end
  endtask

  task automatic test_reset_run;
    logic seen;
    @(negedge clk);
    bus.start = 1'b1; bus.op = MULHU; bus.opA = 32'h80000000; bus.opB = 32'd4; bus.DestR_in = 4'd6;
    for (int c = 2; c <= 21; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1; #1;
    vecs++; if (bus.stall !== 1'b0) begin errs++; $display("FAIL rst_in_run_stall got %b want 0", bus.stall); end
    @(negedge clk);
    rst = 1'b0; #1;
    vecs++; if (bus.busy !== 1'b0 || bus.result !== 32'd0 || bus.DestR_out !== 4'd0 || bus.dz !== 1'b0) begin errs++; $display("FAIL rst_in_run_outputs got %b/%h/%0d/%b want 0/0/0/0", bus.busy, bus.result, bus.DestR_out, bus.dz); end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk); #1;
      if (bus.done) seen = 1'b1;
    end
    vecs++; if (seen !== 1'b0) begin errs++; $display("FAIL rst_in_run_no_done got done seen %b want 0", seen); end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_div;
    test_flush;
    test_start_ignored;
    test_reset_run;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
